// File: rtl/fm_sb_capture_playback.sv
// Fast-monitoring spy buffer: circular capture of a monitored bus with freeze,
// word-wide register readback, and preload-and-playback (once or looped).
module fm_sb_capture_playback #(
    parameter int unsigned DATA_WIDTH    = 256,
    parameter int unsigned AXI_DW        = 32,
    parameter int unsigned DEPTH         = 1024,
    parameter int unsigned PB_MODE_WIDTH = 2,
    localparam int unsigned WPE_CEIL     = (DATA_WIDTH + AXI_DW - 1) / AXI_DW,
    localparam int unsigned WPE          = (DATA_WIDTH <= AXI_DW) ? 1 : WPE_CEIL + (WPE_CEIL % 2),
    localparam int unsigned AW           = $clog2(DEPTH),
    localparam int unsigned RAW          = $clog2(DEPTH * WPE)
) (
    input  logic                     spy_clock,
    input  logic                     spy_rst_n,
    input  logic [DATA_WIDTH-1:0]    in_data,
    input  logic                     in_vld,
    input  logic [PB_MODE_WIDTH-1:0] pb_mode,
    input  logic                     freeze,
    input  logic [AW-1:0]            play_len,
    input  logic                     rd_en,
    input  logic [RAW-1:0]           rd_addr,
    output logic [AXI_DW-1:0]        rd_data,
    output logic                     rd_ack,
    input  logic                     wr_en,
    input  logic [RAW-1:0]           wr_addr,
    input  logic [AXI_DW-1:0]        wr_data,
    output logic                     wr_err,
    output logic [DATA_WIDTH-1:0]    out_data,
    output logic                     out_vld,
    output logic [AW-1:0]            meta_wptr,
    output logic                     meta_wrapped,
    output logic                     meta_frozen,
    output logic                     meta_done
);

    localparam int unsigned EW = WPE * AXI_DW;
    localparam logic [EW-1:0] DATA_MASK = EW'({DATA_WIDTH{1'b1}});
    localparam logic [RAW:0] DEPTH_EXT = (RAW + 1)'(DEPTH);
    localparam logic [PB_MODE_WIDTH-1:0] MODE_SPY  = PB_MODE_WIDTH'(0);
    localparam logic [PB_MODE_WIDTH-1:0] MODE_ONCE = PB_MODE_WIDTH'(1);
    localparam logic [PB_MODE_WIDTH-1:0] MODE_LOOP = PB_MODE_WIDTH'(2);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CAPTURE,
        ST_FROZEN,
        ST_PLAY,
        ST_PLAY_DONE
    } state_t;

    logic [EW-1:0]            mem [DEPTH];
    state_t                   state;
    logic [PB_MODE_WIDTH-1:0] mode_q;
    logic [AW-1:0]            wptr;
    logic [AW-1:0]            rptr;
    logic                     wrapped;
    logic                     frozen;
    logic                     done;

    logic [RAW-1:0] rd_q, rd_r, wr_q, wr_r;
    logic           rd_in_range, wr_in_range;
    logic           cap_we, wr_ok, pre_we;
    logic [AW-1:0]  play_last;

    logic           rd_v1, rd_hit1;
    logic [EW-1:0]  rd_row1;
    logic [RAW-1:0] rd_word1;
    logic           pb_v1;
    logic [DATA_WIDTH-1:0] pb_row1;

    function automatic logic [AXI_DW-1:0] pick_word(input logic [EW-1:0] row,
                                                    input logic [RAW-1:0] idx);
        logic [AXI_DW-1:0] w_out;
        w_out = '0;
        for (int unsigned w = 0; w < WPE; w++) begin
            if (idx == RAW'(w)) w_out = row[w*AXI_DW +: AXI_DW];
        end
        return w_out;
    endfunction

    // Word address splits into entry (quotient) and word (remainder); an entry
    // index beyond DEPTH marks the address out of range.
    always_comb begin
        rd_q        = rd_addr / RAW'(WPE);
        rd_r        = rd_addr % RAW'(WPE);
        wr_q        = wr_addr / RAW'(WPE);
        wr_r        = wr_addr % RAW'(WPE);
        rd_in_range = {1'b0, rd_q} < DEPTH_EXT;
        wr_in_range = {1'b0, wr_q} < DEPTH_EXT;
    end

    assign cap_we    = (state == ST_CAPTURE) && in_vld;
    assign wr_ok     = ((state == ST_IDLE) || (state == ST_FROZEN) || (state == ST_PLAY_DONE))
                       && wr_in_range;
    assign pre_we    = wr_en && wr_ok;
    // play_len of 0 wraps to all-ones here, i.e. DEPTH entries.
    assign play_last = play_len - AW'(1);

    always_ff @(posedge spy_clock) begin
        if (cap_we) mem[wptr] <= EW'(in_data);
        if (pre_we) begin
            for (int unsigned w = 0; w < WPE; w++) begin
                if (wr_r == RAW'(w)) mem[wr_q[AW-1:0]][w*AXI_DW +: AXI_DW] <= wr_data;
            end
        end
    end

    always_ff @(posedge spy_clock or negedge spy_rst_n) begin
        if (!spy_rst_n) begin
            rd_v1    <= 1'b0;
            rd_hit1  <= 1'b0;
            rd_row1  <= '0;
            rd_word1 <= '0;
            rd_ack   <= 1'b0;
            rd_data  <= '0;
            pb_v1    <= 1'b0;
            pb_row1  <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            wr_err   <= 1'b0;
        end else begin
            rd_v1   <= rd_en;
            rd_hit1 <= rd_en && rd_in_range;
            if (rd_en) begin
                rd_row1  <= mem[rd_q[AW-1:0]] & DATA_MASK;
                rd_word1 <= rd_r;
            end
            rd_ack  <= rd_v1;
            rd_data <= rd_hit1 ? pick_word(rd_row1, rd_word1) : '0;

            pb_v1 <= (state == ST_PLAY);
            if (state == ST_PLAY) pb_row1 <= mem[rptr][DATA_WIDTH-1:0];
            out_vld  <= pb_v1;
            out_data <= pb_v1 ? pb_row1 : '0;

            wr_err <= wr_en && !wr_ok;
        end
    end

    always_ff @(posedge spy_clock or negedge spy_rst_n) begin
        if (!spy_rst_n) begin
            state   <= ST_IDLE;
            mode_q  <= '0;
            wptr    <= '0;
            rptr    <= '0;
            wrapped <= 1'b0;
            frozen  <= 1'b0;
            done    <= 1'b0;
        end else if (pb_mode != mode_q) begin
            mode_q <= pb_mode;
            state  <= ST_IDLE;
            frozen <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mode_q == MODE_SPY) begin
                        wptr    <= '0;
                        wrapped <= 1'b0;
                        state   <= ST_CAPTURE;
                    end else if ((mode_q == MODE_ONCE) || (mode_q == MODE_LOOP)) begin
                        rptr  <= '0;
                        done  <= 1'b0;
                        state <= ST_PLAY;
                    end
                end
                ST_CAPTURE: begin
                    if (in_vld) begin
                        wptr <= wptr + AW'(1);
                        if (&wptr) wrapped <= 1'b1;
                    end
                    if (freeze) begin
                        state  <= ST_FROZEN;
                        frozen <= 1'b1;
                    end
                end
                ST_FROZEN: begin
                    if (!freeze) begin
                        state  <= ST_CAPTURE;
                        frozen <= 1'b0;
                    end
                end
                ST_PLAY: begin
                    if (rptr == play_last) begin
                        rptr <= '0;
                        if (mode_q == MODE_ONCE) begin
                            state <= ST_PLAY_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        rptr <= rptr + AW'(1);
                    end
                end
                ST_PLAY_DONE: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign meta_wptr    = wptr;
    assign meta_wrapped = wrapped;
    assign meta_frozen  = frozen;
    assign meta_done    = done;

endmodule
